// File: rtl/md6_pad_scanner.sv
// -----------------------------------------------------------------------------
// md6_pad_scanner
//
// Reads a Sega Mega Drive 3/6-button pad on the DB9 port. The pad select line
// (pin 7) is toggled through the standard 8-phase sequence, the six input
// lines are sampled at the end of selected phases into shadow registers, and
// the complete button word is committed only after the last phase, so a
// partially scanned word is never visible. Between scans the select line is
// held high for IDLE_STEPS phase periods so the 6-button pad's internal edge
// counter times out and restarts cleanly on the next scan.
//
// Parameters:
//   STEP_DIV    clk_sys cycles per select phase (8..65535)
//   IDLE_STEPS  phase periods held idle (select high) between scans
//
// Ports:
//   clk_sys      in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   joy_i        in   6   raw DB9 lines {p9,p6,U,D,L,R}, negative logic, async
//   db9_select   out  1   pad select line (pin 7), registered
//   joy_o        out  12  {M,X,Y,Z,S,A,C,B,R,L,D,U}, negative logic (0=pressed)
//   six_btn      out  1   last scan detected a 6-button pad
//   pad_present  out  1   last scan detected a Mega Drive pad
//   scan_done    out  1   one-cycle pulse when joy_o/six_btn/pad_present update
// -----------------------------------------------------------------------------
module md6_pad_scanner #(
    parameter int unsigned STEP_DIV   = 480,
    parameter int unsigned IDLE_STEPS = 200
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [5:0]  joy_i,
    output logic        db9_select,
    output logic [11:0] joy_o,
    output logic        six_btn,
    output logic        pad_present,
    output logic        scan_done
);

    localparam int unsigned DIV_W  = $clog2(STEP_DIV);
    localparam int unsigned IDLE_W = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_STEPS - 1);
    localparam logic [2:0]        PHASE_LAST = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. Reset to all-ones, the level of released/unplugged
    // lines, so nothing looks pressed straight out of reset.
    // -------------------------------------------------------------------------
    logic [5:0] sync_q1;
    logic [5:0] joy_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as hardware does.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 6'h3F;
            joy_s   <= 6'h3F;
        end else begin
            sync_q1 <= joy_i;
            joy_s   <= sync_q1;
        end
    end

    // -------------------------------------------------------------------------
    // Step timer: free-running 0..STEP_DIV-1. Its last count closes a phase
    // and is the only cycle on which the pad lines are sampled, which leaves
    // the pad almost a whole phase to settle after each select edge.
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             step_end;

    assign step_end = (div_q == DIV_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (step_end) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Scan FSM
    // -------------------------------------------------------------------------
    state_t            state_q,  state_d;
    logic [2:0]        phase_q,  phase_d;
    logic [IDLE_W-1:0] idle_q,   idle_d;
    logic              sel_q,    sel_d;
    logic              commit;
    logic              sample;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            idle_q  <= '0;
            sel_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idle_q  <= idle_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned and no latch appears.
        state_d = state_q;
        phase_d = phase_q;
        idle_d  = idle_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_end) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_SCAN;
                        phase_d = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            ST_SCAN: begin
                if (step_end) begin
                    if (phase_q == PHASE_LAST) begin
                        // Commit and IDLE entry share this cycle.
                        state_d = ST_IDLE;
                        phase_d = '0;
                        commit  = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                idle_d  = '0;
            end
        endcase

        // Select is registered from the next state so pin 7 never glitches;
        // even phases drive it high, odd phases low.
        sel_d = (state_d == ST_IDLE) ? 1'b1 : ~phase_d[0];
    end

    assign sample     = (state_q == ST_SCAN) && step_end;
    assign db9_select = sel_q;

    // -------------------------------------------------------------------------
    // Shadow registers, filled phase by phase.
    //   p0 (high): C,B on p9/p6 and U,D,L,R
    //   p1 (low) : S,A on p9/p6; L and R read low on any Mega Drive pad
    //   p5 (low) : a 6-button pad drives U,D,L,R all low here
    //   p6 (high): a 6-button pad returns Z,Y,X,M on the direction lines
    // -------------------------------------------------------------------------
    logic [11:0] shadow_q;
    logic        pad_ok_q;
    logic        is6_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= 12'hFFF;
            pad_ok_q <= 1'b0;
            is6_q    <= 1'b0;
        end else if (sample) begin
            case (phase_q)
                3'd0: shadow_q[5:0]  <= {joy_s[5], joy_s[4], joy_s[0],
                                         joy_s[1], joy_s[2], joy_s[3]};
                3'd1: begin
                    shadow_q[7:6] <= {joy_s[5], joy_s[4]};
                    pad_ok_q      <= (joy_s[1:0] == 2'b00);
                end
                3'd5: is6_q <= (joy_s[3:0] == 4'b0000);
                3'd6: begin
                    if (is6_q) begin
                        shadow_q[11:8] <= {joy_s[0], joy_s[1],
                                           joy_s[2], joy_s[3]};
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Commit. A 3-button pad reports X/Y/Z/M released; no pad reports
    // everything released.
    // -------------------------------------------------------------------------
    logic [11:0] commit_word;

    always_comb begin
        commit_word = 12'hFFF;
        if (pad_ok_q) begin
            commit_word = is6_q ? shadow_q : {4'hF, shadow_q[7:0]};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_o       <= 12'hFFF;
            six_btn     <= 1'b0;
            pad_present <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            scan_done <= commit;
            if (commit) begin
                joy_o       <= commit_word;
                pad_present <= pad_ok_q;
                six_btn     <= is6_q & pad_ok_q;
            end
        end
    end

endmodule

// File: tb/tb_md6_pad_scanner.sv
// -----------------------------------------------------------------------------
// tb_md6_pad_scanner
//
// Directed bench for md6_pad_scanner with STEP_DIV=8, IDLE_STEPS=2, so one
// scan is (2+8)*8 = 80 clk_sys cycles. A behavioural pad model answers the
// select line as a 3-button pad, a 6-button pad, or an unplugged port; a
// glitch mask can be XORed onto the lines. Expected words are hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_md6_pad_scanner;

    localparam int unsigned STEP_DIV   = 8;
    localparam int unsigned IDLE_STEPS = 2;
    localparam int          PERIOD     = (IDLE_STEPS + 8) * STEP_DIV;

    logic        clk_sys;
    logic        reset_n;
    logic [5:0]  joy_i;
    logic        db9_select;
    logic [11:0] joy_o;
    logic        six_btn;
    logic        pad_present;
    logic        scan_done;

    md6_pad_scanner #(
        .STEP_DIV   (STEP_DIV),
        .IDLE_STEPS (IDLE_STEPS)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .joy_i       (joy_i),
        .db9_select  (db9_select),
        .joy_o       (joy_o),
        .six_btn     (six_btn),
        .pad_present (pad_present),
        .scan_done   (scan_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // -------------------------------------------------------------------------
    // Pad model. held[] uses the joy_o bit order, 1 = pressed.
    // The 6-button pad counts select falling edges; a long high run restarts
    // the count at 1.
    // -------------------------------------------------------------------------
    typedef enum int { PAD_NONE, PAD_3, PAD_6 } pad_t;

    pad_t        pad_type;
    logic [11:0] held;
    logic [5:0]  glitch;
    logic [5:0]  pad_out;
    int          hi_cnt   = 0;
    int          fall_cnt = 0;
    logic        sel_prev = 1'b1;

    always @(posedge clk_sys) begin
        sel_prev <= db9_select;
        hi_cnt   <= db9_select ? hi_cnt + 1 : 0;
        if (sel_prev && !db9_select) begin
            fall_cnt <= (hi_cnt > 12) ? 1 : fall_cnt + 1;
        end
    end

    always_comb begin
        pad_out = 6'h3F;
        if (pad_type != PAD_NONE) begin
            if (db9_select) begin
                if (pad_type == PAD_6 && fall_cnt == 3)
                    pad_out = ~{held[5], held[4], held[8], held[9], held[10], held[11]};
                else
                    pad_out = ~{held[5], held[4], held[0], held[1], held[2], held[3]};
            end else begin
                if (pad_type == PAD_6 && fall_cnt == 3)
                    pad_out = {~held[7], ~held[6], 4'b0000};
                else if (pad_type == PAD_6 && fall_cnt == 4)
                    pad_out = {~held[7], ~held[6], 4'b1111};
                else
                    pad_out = {~held[7], ~held[6], ~held[0], ~held[1], 2'b00};
            end
        end
    end

    assign joy_i = pad_out ^ glitch;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [11:0] e_joy,
                                 input logic e_six, input logic e_pres);
        check({tag, "_joy"},  32'(joy_o),       32'(e_joy));
        check({tag, "_six"},  32'(six_btn),     32'(e_six));
        check({tag, "_pres"}, 32'(pad_present), 32'(e_pres));
    endtask

    // Waits (bounded) for scan_done, sampling on falling edges; returns the
    // number of falling edges it took.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!scan_done && n < 4 * PERIOD);
        check({tag, "_done_seen"}, 32'(scan_done), 32'd1);
    endtask

    // Called on the falling edge where reset_n is released: follows the whole
    // first scan, checking select every cycle and that scan_done fires only
    // on cycle PERIOD.
    task automatic scan_window(input string tag);
        logic exp_sel;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk_sys);
            if (k < 16 || k >= PERIOD) exp_sel = 1'b1;
            else                       exp_sel = (((k - 16) / 8) % 2) == 0;
            check($sformatf("%s_sel_k%0d", tag, k),  32'(db9_select), 32'(exp_sel));
            check($sformatf("%s_done_k%0d", tag, k), 32'(scan_done),  32'(k == PERIOD));
            if (k == 40) check({tag, "_joy_hidden"}, 32'(joy_o), 32'hFFF);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},  32'(db9_select),  32'd1);
        check({tag, "_joy"},  32'(joy_o),       32'hFFF);
        check({tag, "_six"},  32'(six_btn),     32'd0);
        check({tag, "_pres"}, 32'(pad_present), 32'd0);
        check({tag, "_done"}, 32'(scan_done),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int n;

        reset_n  = 1'b0;
        pad_type = PAD_3;
        held     = 12'h048;     // A + Right
        glitch   = 6'h00;

        repeat (3) @(negedge clk_sys);
        check_reset_state("rst");

        // Boot: select waveform and first scan_done at exactly PERIOD cycles.
        reset_n = 1'b1;
        scan_window("boot");
        check_outputs("pad3", 12'hFB7, 1'b0, 1'b1);

        // Free-running period and one-cycle pulse width.
        wait_done("period", n);
        check("period_len", 32'(n), 32'(PERIOD));
        @(negedge clk_sys);
        check("done_pulse", 32'(scan_done), 32'd0);

        // 6-button pad: Start + Z + M.
        wait_done("sync6", n);
        pad_type = PAD_6;
        held     = 12'h980;
        wait_done("pad6", n);
        check_outputs("pad6", 12'h67F, 1'b1, 1'b1);

        // Back to 3-button, then glitches relative to a known scan_done.
        pad_type = PAD_3;
        held     = 12'h048;
        wait_done("pad3b", n);
        check_outputs("pad3b", 12'hFB7, 1'b0, 1'b1);

        // U pulse that the p0 sample never sees.
        repeat (18) @(posedge clk_sys);
        #1 glitch = 6'h08;
        repeat (2) @(posedge clk_sys);
        #1 glitch = 6'h00;
        wait_done("glitch_miss", n);
        check("glitch_miss_joy", 32'(joy_o), 32'hFB7);

        // One-cycle U pulse landing on the p0 sample after the synchronizer.
        repeat (21) @(posedge clk_sys);
        #1 glitch = 6'h08;
        @(posedge clk_sys);
        #1 glitch = 6'h00;
        wait_done("glitch_hit", n);
        check("glitch_hit_joy", 32'(joy_o), 32'hFB6);

        // Unplugged port.
        pad_type = PAD_NONE;
        wait_done("nopad", n);
        check_outputs("nopad", 12'hFFF, 1'b0, 1'b0);

        // Hot-plug mid-scan: correct by the second scan_done.
        repeat (40) @(posedge clk_sys);
        pad_type = PAD_6;
        held     = 12'h980;
        wait_done("plug1", n);
        wait_done("plug2", n);
        check_outputs("plug2", 12'h67F, 1'b1, 1'b1);

        // Reset in phase 3 (select low, outputs populated).
        repeat (40) @(posedge clk_sys);
        #1 check("pre_rst_sel", 32'(db9_select), 32'd0);
        reset_n = 1'b0;
        #1 check_reset_state("midrst");
        repeat (2) @(negedge clk_sys);
        check_reset_state("midrst_hold");
        reset_n = 1'b1;
        scan_window("rerun");
        check_outputs("rerun", 12'h67F, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md6_pad_scanner.md
Name: md6_pad_scanner

Overview:
- Reads a Sega Mega Drive 3/6-button pad on the DB9 port by driving the pad's select line (pin 7) through the standard 8-phase toggle sequence.
- Samples the six DB9 input lines during each phase and presents a stable 12-bit button word, MXYZ SACB RLDU in negative logic, to the emu top-level input mapping.
- Replaces hsync-paced scanning with an internally timed scanner that has pad-type and presence detection.

Parameters:
- STEP_DIV, 480: clk_sys cycles per select phase (10 us at 48 MHz); legal range 8..65535.
- IDLE_STEPS, 200: number of STEP_DIV periods held idle with select high between scans (about 2 ms), so the 6-button pad counter resets.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- joy_i  in  6  raw DB9 lines {p9,p6,U,D,L,R}, negative logic, asynchronous to clk_sys.
- db9_select  out  1  pad select line (pin 7).
- joy_o  out  12  {M,X,Y,Z,S,A,C,B,R,L,D,U}, negative logic (0 = pressed).
- six_btn  out  1  1 = last scan detected a 6-button pad.
- pad_present  out  1  1 = last scan detected a Mega Drive pad.
- scan_done  out  1  one-cycle pulse when joy_o, six_btn and pad_present update.

Behaviour:
- Reset values: db9_select=1, joy_o=12'hFFF, six_btn=0, pad_present=0, scan_done=0. FSM returns to IDLE with all counters cleared.
- Input sync: joy_i passes through a 2-flop synchronizer; the sampled value is joy_s.
- Step timer: a div counter counts 0..STEP_DIV-1. A phase ends when div==STEP_DIV-1. Sampling happens only on that cycle, giving at least STEP_DIV-3 cycles of settle after each select edge.
- FSM states:
  - IDLE: select=1. Counts IDLE_STEPS phase periods, then moves to SCAN with phase=0.
  - SCAN phase p=0..7: select = ~p[0] (phase 0 high, 1 low, ... 7 low). After phase 7 ends, go to IDLE.
- Samples taken at the end of each phase into shadow registers:
  - p0 (select high): U,D,L,R from joy_s[3:0]; B=joy_s[4]; C=joy_s[5].
  - p1 (select low): A=joy_s[4]; S=joy_s[5]; pad_ok = (joy_s[1:0]==2'b00), i.e. L and R read low.
  - p5 (select low): is6 = (joy_s[3:0]==4'b0000).
  - p6 (select high): when is6, Z=joy_s[3], Y=joy_s[2], X=joy_s[1], M=joy_s[0].
  - p2, p3, p4, p7: no samples.
- Commit at the end of phase 7 (same cycle as the SCAN->IDLE transition):
  - pad_present<=pad_ok and six_btn<=is6&pad_ok.
  - joy_o<=shadow word if pad_ok, else 12'hFFF.
  - If !is6, X/Y/Z/M are forced to 1.
  - scan_done pulses for that one cycle.
- Outputs change only at commit; a partial scan is never visible.
- Scan period = (IDLE_STEPS+8)*STEP_DIV cycles, constant and free-running.
- Pad unplugged: inputs float high, so pad_ok=0 and joy_o=FFF.
- Pad hot-plugged mid-scan: one inconsistent scan is possible; the next scan is correct.
- Reset mid-scan: asynchronous return to reset values. select goes high immediately, and a full IDLE period runs before the next scan.
- Simultaneous events: div wrap and phase advance occur in the same cycle. A phase-7 commit and IDLE entry occur together, with no extra cycle.

Test Plan:
- Bench uses STEP_DIV=8, IDLE_STEPS=2 throughout.
- Reset: hold reset_n=0 and assert it again mid-scan -> db9_select=1, joy_o=FFF, six_btn=0, pad_present=0, scan_done=0. First scan_done arrives exactly (2+8)*8 (+ sync) cycles after release.
- Select waveform: observe db9_select -> high for 16 cycles (idle), then the 8-phase sequence H,L,H,L,H,L,H,L of 8 cycles each. scan_done pulses once per 80 cycles.
- 3-button pad model, A+Right held (low at p1 L/R, p5 UDLR not all low) -> joy_o=12'hFB7 (A bit6=0, R bit3=0), six_btn=0, pad_present=1.
- 6-button pad model, Start+Z+M held -> joy_o=12'h67F (bits 11, 8, 7 cleared), six_btn=1, pad_present=1.
- No pad (joy_i=6'h3F constant) -> joy_o=FFF, pad_present=0, six_btn=0. A pad attached mid-scan gives correct values by the second scan_done.
- Glitch: a button pulse changes joy_i between sample points only -> joy_o unchanged. A 1-cycle pulse on the sample cycle (after sync delay) is captured in the next commit.
